block_scheduler: RTL and testbench
==================================

BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of compute cores served (range 1..16).
REQ-002 SHALL have parameter DIM_W, default 16: width of each grid dimension and block coordinate.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset rst, synchronous, active-high.
REQ-005 SHALL have port launch_valid  input  1  kernel launch request.
REQ-006 SHALL have port launch_ready  output  1  high only in IDLE; launch accepted when launch_valid && launch_ready.
REQ-007 SHALL have port grid_x  input  DIM_W  blocks in x; sampled at launch.
REQ-008 SHALL have port grid_y  input  DIM_W  blocks in y; sampled at launch.
REQ-009 SHALL have port abort  input  1  stop issuing new blocks.
REQ-010 SHALL have port core_idle  input  NUM_CORES  core i can accept a block this cycle.
REQ-011 SHALL have port core_done  input  NUM_CORES  one-cycle pulse: core i finished its block.
REQ-012 SHALL have port disp_valid  output  NUM_CORES  one-hot or zero; one-cycle dispatch strobe to core i.
REQ-013 SHALL have port disp_block_x  output  DIM_W  x coordinate of dispatched block.
REQ-014 SHALL have port disp_block_y  output  DIM_W  y coordinate of dispatched block.
REQ-015 SHALL have port disp_block_lin  output  2*DIM_W  linear id = y*grid_x + x.
REQ-016 SHALL have port blocks_done_cnt  output  2*DIM_W  blocks completed in current kernel.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port kernel_done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port aborted  output  1  high with kernel_done when the kernel ended via abort.

Function
REQ-020 SHALL implement states IDLE, DISPATCH, DRAIN, DONE.
REQ-021 SHALL, on accepted launch, latch grid_x, grid_y, total = grid_x*grid_y (2*DIM_W bits, no truncation), clear coordinate counters, blocks_done_cnt and inflight, and go IDLE->DISPATCH.
REQ-022 SHALL, if total == 0 at launch, go IDLE->DONE directly with no dispatch.
REQ-023 SHALL keep per-core inflight bit; core i eligible iff core_idle[i] && !inflight[i] (pre-update value of the cycle).
REQ-024 SHALL, in DISPATCH with issued < total and at least one eligible core, grant exactly one core per cycle by round-robin starting at (last granted + 1) mod NUM_CORES; after reset the pointer starts at core 0.
REQ-025 SHALL register grants: disp_valid[i] and disp_block_* appear the cycle after the grant decision; first disp_valid is 2 cycles after launch handshake; inflight[i] sets at grant.
REQ-026 SHALL hold disp_block_* at last issued value while disp_valid is 0.
REQ-027 SHALL step coordinates x = x+1; when x == grid_x-1, x wraps to 0 and y = y+1; disp_block_lin increments by 1 per dispatch (running counter, no multiplier).
REQ-028 SHALL, on core_done[i] with inflight[i], clear inflight[i] and add to blocks_done_cnt; multiple simultaneous dones count individually (popcount).
REQ-029 SHALL ignore core_done[i] when inflight[i] == 0.
REQ-030 SHALL, when core_done[i] and eligibility evaluation coincide, not grant core i that cycle; it becomes eligible the next cycle.
REQ-031 SHALL go DISPATCH->DRAIN when issued == total, or when abort is high (abort takes effect the same cycle; no grant that cycle).
REQ-032 SHALL go DRAIN->DONE when all inflight bits are 0, including the cycle a final core_done clears the last bit.
REQ-033 SHALL, in DONE, assert kernel_done for exactly one cycle (aborted = 1 if abort caused the exit) then return to IDLE.
REQ-034 SHALL ignore launch_valid outside IDLE and abort in IDLE/DONE.

Reset
REQ-035 SHALL on rst force IDLE; disp_valid, disp_block_x/y/lin, blocks_done_cnt, inflight, kernel_done, aborted, busy = 0; launch_ready = 1; RR pointer = 0.
REQ-036 SHALL let rst override every other input, including mid-kernel; in-flight blocks are forgotten and later core_done pulses are ignored.

Verification
REQ-037 SHALL test: NUM_CORES=4, grid 3x2, cores always idle, done 5 cycles after dispatch -> six dispatches (0,0),(1,0),(2,0),(0,1),(1,1),(2,1), lin 0..5, cores 0,1,2,3,0,1, one kernel_done, blocks_done_cnt=6.
REQ-038 SHALL test: grid_x=0, grid_y=7 -> no disp_valid, kernel_done 2 cycles after launch handshake (DONE then IDLE), aborted=0.
REQ-039 SHALL test: grid 4x4, only core 2 idle -> all 16 blocks to core 2, each dispatch only after its prior core_done; no back-to-back grant in the done cycle.
REQ-040 SHALL test: grid 10x10, abort after 5 dispatches with 3 inflight -> no further disp_valid, kernel_done after the 3 dones, aborted=1, blocks_done_cnt=5.
REQ-041 SHALL test: cores 0 and 3 core_done in same cycle -> blocks_done_cnt increments by 2; spurious core_done on non-inflight core 1 -> no change.
REQ-042 SHALL test: rst asserted mid-DISPATCH of grid 8x8 -> next cycle IDLE, launch_ready=1, all outputs at reset values; new 1x1 launch completes normally.

Source files
------------

// File: rtl/block_scheduler_if.sv
// Launch, dispatch and completion signals between a kernel launcher,
// the block scheduler and its compute cores.
interface block_scheduler_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned DIM_W     = 16
);
    logic                   launch_valid;
    logic                   launch_ready;
    logic [DIM_W-1:0]       grid_x;
    logic [DIM_W-1:0]       grid_y;
    logic                   abort;
    logic [NUM_CORES-1:0]   core_idle;
    logic [NUM_CORES-1:0]   core_done;
    logic [NUM_CORES-1:0]   disp_valid;
    logic [DIM_W-1:0]       disp_block_x;
    logic [DIM_W-1:0]       disp_block_y;
    logic [2*DIM_W-1:0]     disp_block_lin;
    logic [2*DIM_W-1:0]     blocks_done_cnt;
    logic                   busy;
    logic                   kernel_done;
    logic                   aborted;

    modport master (
        output launch_valid, grid_x, grid_y, abort, core_idle, core_done,
        input  launch_ready, disp_valid, disp_block_x, disp_block_y, disp_block_lin,
        input  blocks_done_cnt, busy, kernel_done, aborted
    );

    modport slave (
        input  launch_valid, grid_x, grid_y, abort, core_idle, core_done,
        output launch_ready, disp_valid, disp_block_x, disp_block_y, disp_block_lin,
        output blocks_done_cnt, busy, kernel_done, aborted
    );
endinterface

// File: rtl/block_scheduler.sv
// Issues the blocks of a 2-D kernel grid to idle compute cores, one grant per cycle
// in round-robin order, and tracks completions until the kernel drains.
module block_scheduler #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned DIM_W     = 16
) (
    input logic              clk,
    input logic              rst,
    block_scheduler_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W = 2 * DIM_W;

    typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [DIM_W-1:0]     grid_x_q;
    logic [DIM_W-1:0]     x_q, y_q;
    logic [CNT_W-1:0]     total_q, issued_q;
    logic [CNT_W-1:0]     done_cnt_q;
    logic [NUM_CORES-1:0] inflight_q, disp_valid_q;
    logic [DIM_W-1:0]     disp_x_q, disp_y_q;
    logic [CNT_W-1:0]     disp_lin_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic                 abort_seen_q, kernel_done_q, aborted_q;

    logic                 launch_fire, grant_en, do_grant, grant_found, remaining;
    logic [CNT_W-1:0]     launch_total, done_inc;
    logic [NUM_CORES-1:0] eligible, done_hit, grant, inflight_d;
    logic [PTR_W-1:0]     next_ptr;

    assign launch_total = {{DIM_W{1'b0}}, bus.grid_x} * {{DIM_W{1'b0}}, bus.grid_y};
    assign remaining    = (issued_q != total_q);
    // Eligibility uses the pre-update inflight, so a core finishing this cycle waits one more.
    assign eligible     = bus.core_idle & ~inflight_q;
    assign done_hit     = bus.core_done & inflight_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.launch_valid) begin
                    state_d = (launch_total == '0) ? StDone : StDispatch;
                end
            end
            StDispatch: begin
                if (bus.abort || !remaining) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (inflight_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.launch_ready = (state_q == StIdle);
        bus.busy         = (state_q != StIdle);
        launch_fire      = (state_q == StIdle) && bus.launch_valid;
        grant_en         = (state_q == StDispatch) && !bus.abort && remaining;
    end

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        next_ptr    = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!grant_found && (((eligible >> idx) & NUM_CORES'(1)) != '0)) begin
                grant_found = 1'b1;
                grant       = NUM_CORES'(1) << idx;
                next_ptr    = (idx + 1 >= NUM_CORES) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    assign do_grant   = grant_en && grant_found;
    assign inflight_d = (inflight_q & ~bus.core_done) | (do_grant ? grant : '0);

    always_comb begin
        done_inc = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            done_inc = done_inc + CNT_W'(done_hit[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grid_x_q      <= '0;
            x_q           <= '0;
            y_q           <= '0;
            total_q       <= '0;
            issued_q      <= '0;
            done_cnt_q    <= '0;
            inflight_q    <= '0;
            disp_valid_q  <= '0;
            disp_x_q      <= '0;
            disp_y_q      <= '0;
            disp_lin_q    <= '0;
            rr_ptr_q      <= '0;
            abort_seen_q  <= 1'b0;
            kernel_done_q <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            disp_valid_q  <= do_grant ? grant : '0;
            inflight_q    <= launch_fire ? '0 : inflight_d;
            kernel_done_q <= (state_q == StDone);
            aborted_q     <= (state_q == StDone) && abort_seen_q;
            if (launch_fire) begin
                grid_x_q     <= bus.grid_x;
                total_q      <= launch_total;
                issued_q     <= '0;
                x_q          <= '0;
                y_q          <= '0;
                done_cnt_q   <= '0;
                abort_seen_q <= 1'b0;
            end else begin
                done_cnt_q <= done_cnt_q + done_inc;
                if ((state_q == StDispatch) && bus.abort && remaining) begin
                    abort_seen_q <= 1'b1;
                end
                if (do_grant) begin
                    disp_x_q   <= x_q;
                    disp_y_q   <= y_q;
                    disp_lin_q <= issued_q;
                    issued_q   <= issued_q + CNT_W'(1);
                    rr_ptr_q   <= next_ptr;
                    if (x_q == grid_x_q - DIM_W'(1)) begin
                        x_q <= '0;
                        y_q <= y_q + DIM_W'(1);
                    end else begin
                        x_q <= x_q + DIM_W'(1);
                    end
                end
            end
        end
    end

    assign bus.disp_valid      = disp_valid_q;
    assign bus.disp_block_x    = disp_x_q;
    assign bus.disp_block_y    = disp_y_q;
    assign bus.disp_block_lin  = disp_lin_q;
    assign bus.blocks_done_cnt = done_cnt_q;
    assign bus.kernel_done     = kernel_done_q;
    assign bus.aborted         = aborted_q;
endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler: a table of kernel launches with expected dispatch
// order and completion results, plus hand sequences for done counting and mid-kernel reset.
module tb_block_scheduler;
    localparam int NC = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_scheduler_if #(.NUM_CORES(NC), .DIM_W(DW)) bus ();

    block_scheduler #(.NUM_CORES(NC), .DIM_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          gx;
        int          gy;
        logic [3:0]  idle;
        int          delay;
        int          abort_after;
        int          exp_n;
        int          exp_cnt;
        bit          exp_abort;
        logic [63:0] seq;
    } vec_t;

    vec_t vecs[5];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_launch_ready"}, bus.launch_ready, 1);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_disp_valid"}, bus.disp_valid, 0);
        chk({tag, "_disp_x"}, bus.disp_block_x, 0);
        chk({tag, "_disp_y"}, bus.disp_block_y, 0);
        chk({tag, "_disp_lin"}, bus.disp_block_lin, 0);
        chk({tag, "_done_cnt"}, bus.blocks_done_cnt, 0);
        chk({tag, "_kernel_done"}, bus.kernel_done, 0);
        chk({tag, "_aborted"}, bus.aborted, 0);
    endtask

    task automatic do_reset(input string tag);
        rst              = 1'b1;
        bus.launch_valid = 1'b0;
        bus.abort        = 1'b0;
        bus.core_done    = '0;
        bus.core_idle    = '0;
        bus.grid_x       = '0;
        bus.grid_y       = '0;
        step();
        step();
        check_reset_outputs(tag);
        rst = 1'b0;
    endtask

    task automatic run_kernel(input int gx, input int gy, input logic [3:0] idle,
                              input int delay, input int abort_after, input int exp_n,
                              input int exp_cnt, input bit exp_abort, input logic [63:0] seq,
                              input string tag);
        int         t, n, first_t, done_t, core;
        int         cnt[NC];
        logic [3:0] outstanding, done_prev, new_mask, drive;
        bit         abort_sent, finished;
        t = 1; n = 0; first_t = -1; done_t = -1; core = 0;
        outstanding = '0; done_prev = '0;
        abort_sent = 1'b0; finished = 1'b0;
        for (int i = 0; i < NC; i++) cnt[i] = 0;

        bus.core_idle    = idle;
        bus.grid_x       = DW'(gx);
        bus.grid_y       = DW'(gy);
        bus.launch_valid = 1'b1;
        step();
        bus.launch_valid = 1'b0;
        chk({tag, "_ready_after_launch"}, bus.launch_ready, 0);
        chk({tag, "_busy_after_launch"}, bus.busy, 1);

        while (!finished && t < 600) begin
            new_mask = '0;
            if (bus.disp_valid != '0) begin
                chk({tag, "_onehot"}, $onehot(bus.disp_valid), 1);
                for (int i = 0; i < NC; i++) if (bus.disp_valid[i]) core = i;
                chk({tag, "_disp_to_busy_core"}, outstanding[core], 0);
                chk({tag, "_disp_to_nonidle"}, idle[core], 1);
                if (n < 16) chk({tag, "_core"}, core, (seq >> (4 * n)) & 64'hf);
                chk({tag, "_x"}, bus.disp_block_x, n % gx);
                chk({tag, "_y"}, bus.disp_block_y, n / gx);
                chk({tag, "_lin"}, bus.disp_block_lin, n);
                if (first_t < 0) first_t = t;
                n++;
                new_mask[core] = 1'b1;
            end else if (n > 0) begin
                chk({tag, "_hold_lin"}, bus.disp_block_lin, n - 1);
            end
            outstanding = (outstanding & ~done_prev) | new_mask;

            drive = '0;
            for (int i = 0; i < NC; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) drive[i] = 1'b1;
                end
            end
            if (new_mask != '0) cnt[core] = delay;
            bus.core_done = drive;
            done_prev     = drive;

            if (bus.kernel_done) begin
                done_t = t;
                chk({tag, "_aborted"}, bus.aborted, exp_abort);
                finished = 1'b1;
            end

            if (abort_after > 0 && n == abort_after && !abort_sent) begin
                bus.abort  = 1'b1;
                abort_sent = 1'b1;
            end else begin
                bus.abort = 1'b0;
            end

            if (!finished) begin
                step();
                t++;
            end
        end

        bus.core_done = '0;
        bus.abort     = 1'b0;
        if (!finished) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_num_dispatches"}, n, exp_n);
        chk({tag, "_blocks_done_cnt"}, bus.blocks_done_cnt, exp_cnt);
        if (exp_n > 0) chk({tag, "_first_disp_cycle"}, first_t, 2);
        else           chk({tag, "_kernel_done_cycle"}, done_t, 2);
        step();
        chk({tag, "_kernel_done_pulse"}, bus.kernel_done, 0);
        chk({tag, "_ready_at_end"}, bus.launch_ready, 1);
        chk({tag, "_busy_at_end"}, bus.busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // gx, gy, idle, delay, abort_after, exp_n, exp_cnt, exp_abort, core sequence (nibble 0 first)
        vecs[0] = '{3, 2, 4'b1111, 5, 0, 6, 6, 1'b0, 64'h0000_0000_0010_3210};
        vecs[1] = '{0, 7, 4'b1111, 5, 0, 0, 0, 1'b0, 64'h0};
        vecs[2] = '{4, 4, 4'b0100, 3, 0, 16, 16, 1'b0, 64'h2222_2222_2222_2222};
        vecs[3] = '{10, 10, 4'b1111, 2, 5, 5, 5, 1'b1, 64'h0000_0000_0000_3210};
        vecs[4] = '{1, 1, 4'b1111, 1, 0, 1, 1, 1'b0, 64'h0};

        for (int v = 0; v < 5; v++) begin
            do_reset($sformatf("v%0d_reset", v));
            run_kernel(vecs[v].gx, vecs[v].gy, vecs[v].idle, vecs[v].delay, vecs[v].abort_after,
                       vecs[v].exp_n, vecs[v].exp_cnt, vecs[v].exp_abort, vecs[v].seq,
                       $sformatf("v%0d", v));
        end

        // Simultaneous and spurious core_done on an 8x8 kernel served by cores 0 and 3.
        do_reset("dn_reset");
        bus.core_idle    = 4'b1001;
        bus.grid_x       = 16'd8;
        bus.grid_y       = 16'd8;
        bus.launch_valid = 1'b1;
        step();
        bus.launch_valid = 1'b0;
        step();
        chk("dn_first_disp", bus.disp_valid, 4'b0001);
        step();
        chk("dn_second_disp", bus.disp_valid, 4'b1000);
        step();
        chk("dn_no_third_disp", bus.disp_valid, 4'b0000);
        chk("dn_cnt_before", bus.blocks_done_cnt, 0);
        bus.core_done = 4'b1011;
        step();
        bus.core_done = 4'b0000;
        chk("dn_cnt_pair", bus.blocks_done_cnt, 2);
        bus.core_done = 4'b0010;
        step();
        bus.core_done = 4'b0000;
        chk("dn_cnt_spurious", bus.blocks_done_cnt, 2);
        chk("dn_still_busy", bus.busy, 1);

        // Reset while that kernel is still dispatching, then a fresh 1x1 kernel.
        rst = 1'b1;
        step();
        check_reset_outputs("mid_rst");
        rst           = 1'b0;
        bus.core_done = 4'b1111;
        step();
        bus.core_done = 4'b0000;
        chk("mid_rst_done_ignored", bus.blocks_done_cnt, 0);
        chk("mid_rst_no_disp", bus.disp_valid, 0);
        run_kernel(1, 1, 4'b1111, 1, 0, 1, 1, 1'b0, 64'h0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
